cache_fill_fsm: RTL and testbench

Miss-handling initiator that sits between the cache tag/data arrays and the 4-cycle-latency, 16-bit, byte-addressed memory.
- On a cache miss it issues back-to-back word reads for the whole block, one per cycle.
- It collects the pipelined responses qualified by the memory's data-valid, and writes each returned word into the cache data array.
- When the last word lands it writes the tag and reports completion.

---
 rtl/cache_fill_fsm.sv | 121 ++++++++++++
 tb/tb_cache_fill_fsm.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: block-fill initiator for a cache miss.
// Issues one word read per cycle for the whole block, writes each returned
// word into the data array in arrival order, then writes the tag and pulses
// fill_done. Memory responses arrive in request order with fixed latency, so
// the receive counter alone selects the data-array offset.
module cache_fill_fsm #(
  parameter int ADDR_WIDTH      = 16,
  parameter int WORDS_PER_BLOCK = 8,
  parameter int OFFSET_BITS     = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   miss_detected,
  input  logic [ADDR_WIDTH-1:0]  miss_address,
  input  logic                   memory_data_valid,
  input  logic [15:0]            memory_data,
  output logic                   mem_enable,
  output logic                   mem_wr,
  output logic [ADDR_WIDTH-1:0]  memory_address,
  output logic                   fsm_busy,
  output logic                   write_data_array,
  output logic [OFFSET_BITS-1:0] cache_word_offset,
  output logic [15:0]            cache_data,
  output logic                   write_tag_array,
  output logic                   fill_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    TAG  = 2'd2
  } state_t;

  // Counters are one bit wider than the offset so "all words issued" is
  // representable without a separate flag.
  localparam logic [OFFSET_BITS:0] WORDS     = (OFFSET_BITS+1)'(WORDS_PER_BLOCK);
  localparam logic [OFFSET_BITS:0] LAST_WORD = (OFFSET_BITS+1)'(WORDS_PER_BLOCK - 1);
  // Clears the word offset and the byte-in-word bit: block-aligned base.
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
    ~(ADDR_WIDTH'((1 << (OFFSET_BITS + 1)) - 1));

  state_t                  state_reg, state_next;
  logic [ADDR_WIDTH-1:0]   base_addr_reg, base_addr_next;
  logic [OFFSET_BITS:0]    issue_cnt_reg, issue_cnt_next;
  logic [OFFSET_BITS:0]    recv_cnt_reg, recv_cnt_next;

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      base_addr_reg <= '0;
      issue_cnt_reg <= '0;
      recv_cnt_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      base_addr_reg <= base_addr_next;
      issue_cnt_reg <= issue_cnt_next;
      recv_cnt_reg  <= recv_cnt_next;
    end
  end

  // Next-state, counter updates and all outputs, decoded from current state.
  always_comb begin
    state_next        = state_reg;
    base_addr_next    = base_addr_reg;
    issue_cnt_next    = issue_cnt_reg;
    recv_cnt_next     = recv_cnt_reg;
    mem_enable        = 1'b0;
    mem_wr            = 1'b0;
    memory_address    = '0;
    fsm_busy          = 1'b0;
    write_data_array  = 1'b0;
    cache_word_offset = '0;
    cache_data        = memory_data;
    write_tag_array   = 1'b0;
    fill_done         = 1'b0;

    case (state_reg)
      IDLE: begin
        // Stray valids here are ignored; only a miss starts a fill.
        if (miss_detected) begin
          base_addr_next = miss_address & ALIGN_MASK;
          issue_cnt_next = '0;
          recv_cnt_next  = '0;
          state_next     = FILL;
        end
      end

      FILL: begin
        fsm_busy          = 1'b1;
        cache_word_offset = recv_cnt_reg[OFFSET_BITS-1:0];
        if (issue_cnt_reg < WORDS) begin
          mem_enable     = 1'b1;
          memory_address = base_addr_reg + ADDR_WIDTH'({issue_cnt_reg, 1'b0});
          issue_cnt_next = issue_cnt_reg + 1'b1;
        end else begin
          memory_address = base_addr_reg;
        end
        if (memory_data_valid) begin
          write_data_array = 1'b1;
          recv_cnt_next    = recv_cnt_reg + 1'b1;
          if (recv_cnt_reg == LAST_WORD) begin
            state_next = TAG;
          end
        end
      end

      TAG: begin
        fsm_busy        = 1'b1;
        write_tag_array = 1'b1;
        fill_done       = 1'b1;
        state_next      = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Testbench for cache_fill_fsm: a 4-cycle memory model feeds the DUT,
// stimulus pushes expected requests/writes/tag pulses into queues, and a
// negedge monitor pops and compares whenever the DUT presents them.
module tb_cache_fill_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        memory_data_valid;
  logic [15:0] memory_data;
  logic        mem_enable;
  logic        mem_wr;
  logic [15:0] memory_address;
  logic        fsm_busy;
  logic        write_data_array;
  logic [2:0]  cache_word_offset;
  logic [15:0] cache_data;
  logic        write_tag_array;
  logic        fill_done;

  typedef struct {
    int          cyc;
    logic [15:0] val;
    logic [2:0]  off;
  } exp_t;

  exp_t req_q[$];
  exp_t wr_q[$];
  exp_t tag_q[$];

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int busy_cnt   = 0;
  int busy_exp   = 0;

  logic [15:0] data_base = 16'h0;
  logic        inj_valid = 1'b0;
  logic [3:0]  pv;
  logic [15:0] pd [4];

  cache_fill_fsm #(
    .ADDR_WIDTH(16), .WORDS_PER_BLOCK(8), .OFFSET_BITS(3)
  ) dut (
    .clk(clk), .rst(rst),
    .miss_detected(miss_detected), .miss_address(miss_address),
    .memory_data_valid(memory_data_valid), .memory_data(memory_data),
    .mem_enable(mem_enable), .mem_wr(mem_wr), .memory_address(memory_address),
    .fsm_busy(fsm_busy), .write_data_array(write_data_array),
    .cache_word_offset(cache_word_offset), .cache_data(cache_data),
    .write_tag_array(write_tag_array), .fill_done(fill_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: a request presented in cycle n returns valid data in cycle
  // n+4. Word value is data_base plus the word index within the block.
  always @(posedge clk) begin
    if (rst) begin
      pv <= 4'b0;
    end else begin
      pv    <= {pv[2:0], mem_enable};
      pd[0] <= data_base + {13'd0, memory_address[3:1]};
      pd[1] <= pd[0];
      pd[2] <= pd[1];
      pd[3] <= pd[2];
    end
  end

  assign memory_data_valid = pv[3] | inj_valid;
  assign memory_data       = pd[3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pop and compare each request, array write and tag pulse.
  always @(negedge clk) begin
    exp_t e;
    if (mem_wr !== 1'b0) check("mem_wr_zero", {31'd0, mem_wr}, 0);
    if (fsm_busy === 1'b1) busy_cnt++;
    if (mem_enable === 1'b1) begin
      if (req_q.size() == 0) begin
        check("req_unexpected", memory_address, 32'hFFFF_FFFF);
      end else begin
        e = req_q.pop_front();
        check("req_cycle", cyc, e.cyc);
        check("req_addr", memory_address, e.val);
        $display("req  cyc %0d addr %04h", cyc, memory_address);
      end
    end
    if (write_data_array === 1'b1) begin
      if (wr_q.size() == 0) begin
        check("wr_unexpected", cache_data, 32'hFFFF_FFFF);
      end else begin
        e = wr_q.pop_front();
        check("wr_cycle", cyc, e.cyc);
        check("wr_offset", cache_word_offset, e.off);
        check("wr_data", cache_data, e.val);
        $display("wr   cyc %0d off %0d data %04h", cyc, cache_word_offset, cache_data);
      end
    end
    if (write_tag_array === 1'b1 || fill_done === 1'b1) begin
      check("tag_done_coincide", {31'd0, fill_done}, {31'd0, write_tag_array});
      if (tag_q.size() == 0) begin
        check("tag_unexpected", cyc, 32'hFFFF_FFFF);
      end else begin
        e = tag_q.pop_front();
        check("tag_cycle", cyc, e.cyc);
        $display("tag  cyc %0d", cyc);
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_enable"}, mem_enable, 0);
    check({tag, "_memory_address"}, memory_address, 0);
    check({tag, "_fsm_busy"}, fsm_busy, 0);
    check({tag, "_write_data_array"}, write_data_array, 0);
    check({tag, "_cache_word_offset"}, cache_word_offset, 0);
    check({tag, "_write_tag_array"}, write_tag_array, 0);
    check({tag, "_fill_done"}, fill_done, 0);
  endtask

  // Called at a negedge; drives the miss for one sampling edge and queues the
  // expected response. Returns at the negedge of fill cycle 1.
  task automatic start_miss(input logic [15:0] addr, input logic [15:0] db,
                            input int nreq, input int nwr, input bit tag);
    logic [15:0] base;
    int e0;
    exp_t x;
    base          = addr & 16'hFFF0;
    e0            = cyc + 1;
    data_base     = db;
    miss_detected = 1'b1;
    miss_address  = addr;
    for (int i = 0; i < nreq; i++) begin
      x.cyc = e0 + i; x.val = base + 16'(2 * i); x.off = 3'(i);
      req_q.push_back(x);
    end
    for (int i = 0; i < nwr; i++) begin
      x.cyc = e0 + 4 + i; x.val = db + 16'(i); x.off = 3'(i);
      wr_q.push_back(x);
    end
    if (tag) begin
      x.cyc = e0 + 12; x.val = 16'h0; x.off = 3'd0;
      tag_q.push_back(x);
    end
    @(negedge clk);
    miss_detected = 1'b0;
  endtask

  // Full fill; returns at the negedge of cycle 14 (back in IDLE).
  task automatic do_fill(input logic [15:0] addr, input logic [15:0] db);
    start_miss(addr, db, 8, 8, 1'b1);
    busy_exp += 13;
    repeat (13) @(negedge clk);
    check("idle_after_fill_busy", fsm_busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    miss_detected = 1'b0;
    miss_address  = 16'h0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    // Stray valid in IDLE must not write the array.
    inj_valid = 1'b1;
    #1;
    check_all_zero("idle_valid");
    @(negedge clk);
    inj_valid = 1'b0;

    // Single miss: 0x1236 -> 0x1230..0x123E, data 0xA000..0xA007.
    do_fill(16'h1236, 16'hA000);

    // Miss held during an active fill must be ignored.
    @(negedge clk);
    start_miss(16'h1230, 16'hB000, 8, 8, 1'b1);
    busy_exp += 13;
    miss_detected = 1'b1;
    miss_address  = 16'h4000;
    repeat (12) @(negedge clk);
    miss_detected = 1'b0;
    @(negedge clk);
    check("ignored_miss_idle", {fsm_busy, mem_enable}, 0);
    @(negedge clk);
    do_fill(16'h4002, 16'h5000);

    // Back-to-back: second miss in the IDLE cycle right after fill_done.
    @(negedge clk);
    do_fill(16'h0010, 16'h1000);
    do_fill(16'h0020, 16'h2000);

    // Reset asserted in cycle 7: 7 requests, 3 writes, no tag.
    @(negedge clk);
    start_miss(16'h0080, 16'h3000, 7, 3, 1'b0);
    busy_exp += 7;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_all_zero("mid_fill_reset");
    @(negedge clk);
    do_fill(16'h0100, 16'h4000);

    // Top of address space: 0xFFFF -> 0xFFF0..0xFFFE.
    @(negedge clk);
    do_fill(16'hFFFF, 16'hC000);

    repeat (6) @(negedge clk);
    check("req_q_drained", req_q.size(), 0);
    check("wr_q_drained", wr_q.size(), 0);
    check("tag_q_drained", tag_q.size(), 0);
    check("busy_cycles", busy_cnt, busy_exp);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
